// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared constants and types for the 5-stage RISC-V pipeline.
//   NOP_INSTR        : canonical bubble instruction (addi x0,x0,0)
//   INSTR_BYTES      : byte distance between consecutive instructions
//   DEFAULT_RESET_PC : PC value loaded on reset unless overridden
//   ifid_action_e    : what the IF/ID register does on a given edge
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IFID_LOAD   = 2'd0,
        IFID_HOLD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_action_e;

endpackage

// File: rtl/pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg
// Program counter register with next-PC selection.
// Ports:
//   clk, rst     : clock and asynchronous active-high reset
//   stall_f      : hold the PC (ignored when a redirect is requested)
//   pc_src_e     : redirect request from Execute
//   pc_target_e  : redirect target (bit 0 is forced to zero)
//   pc           : current PC (registered)
//   pc_plus4     : current PC + 4, modulo 2^ADDR_WIDTH
// ---------------------------------------------------------------------------
module pc_reg
    import riscv_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_f,
    input  logic                  pc_src_e,
    input  logic [ADDR_WIDTH-1:0] pc_target_e,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4
);

    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(INSTR_BYTES);
    localparam logic [ADDR_WIDTH-1:0] LSB_MASK = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  pc_en;

    assign pc_plus4 = pc + STEP;

    // A redirect overrides a stall: the branch resolution must not be lost
    // while the front end is held. Targets always have bit 0 cleared (jalr).
    always_comb begin
        next_pc = pc_plus4;
        pc_en   = ~stall_f | pc_src_e;
        if (pc_src_e) begin
            next_pc = pc_target_e & LSB_MASK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (pc_en) begin
            pc <= next_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, drives the combinational instruction
// memory and captures the returned word into the IF/ID pipeline register.
// Ports:
//   clk, rst      : clock and asynchronous active-high reset
//   stall_f       : hold PC and IF/ID (load-use hazard)
//   flush_d       : replace IF/ID with a bubble (wins over stall_f)
//   pc_src_e      : redirect request from Execute; pc_target_e is the target
//   imem_addr     : byte address to instruction memory (= PC register)
//   imem_rdata    : instruction word returned for imem_addr
//   instr_d, pc_d, pc_plus4_d, valid_d : IF/ID register contents
//   misalign_f    : sticky flag, set by a redirect target with bit 1 set
//   fetch_count   : number of real instructions loaded into IF/ID
// ---------------------------------------------------------------------------
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_f,
    input  logic                  flush_d,
    input  logic                  pc_src_e,
    input  logic [ADDR_WIDTH-1:0] pc_target_e,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic [INST_WIDTH-1:0] instr_d,
    output logic [ADDR_WIDTH-1:0] pc_d,
    output logic [ADDR_WIDTH-1:0] pc_plus4_d,
    output logic                  valid_d,
    output logic                  misalign_f,
    output logic [31:0]           fetch_count
);

    localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(NOP_INSTR);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    ifid_action_e          ifid_action;

    pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .stall_f     (stall_f),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    assign imem_addr = pc;

    // IF/ID action: a flush beats a stall so a wrong-path word can never
    // linger in Decode behind a load-use hold.
    always_comb begin
        ifid_action = IFID_LOAD;
        if (flush_d) begin
            ifid_action = IFID_BUBBLE;
        end else if (stall_f) begin
            ifid_action = IFID_HOLD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_d    <= NOP;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else begin
            case (ifid_action)
                IFID_BUBBLE: begin
                    instr_d    <= NOP;
                    pc_d       <= '0;
                    pc_plus4_d <= '0;
                    valid_d    <= 1'b0;
                end
                IFID_LOAD: begin
                    instr_d    <= imem_rdata;
                    pc_d       <= pc;
                    pc_plus4_d <= pc_plus4;
                    valid_d    <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Misalignment only looks at bit 1: bit 0 is discarded by the jalr rule,
    // so a target like 0x25 lands on a legal word address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_f <= 1'b0;
        end else if (pc_src_e && pc_target_e[1]) begin
            misalign_f <= 1'b1;
        end
    end

    // Counts real loads only; bubbles and held cycles are not fetches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (ifid_action == IFID_LOAD) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage with a behavioural model of the PC and
// IF/ID register, directed scenarios and a randomized hazard/redirect phase.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall_f;
    logic        flush_d;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        misalign_f;
    logic [31:0] fetch_count;

    int checks;
    int passes;
    bit checking;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_mis;
    logic [31:0] m_count;

    logic [31:0] saved_count;

    fetch_stage #(
        .ADDR_WIDTH (32),
        .INST_WIDTH (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_f     (stall_f),
        .flush_d     (flush_d),
        .pc_src_e    (pc_src_e),
        .pc_target_e (pc_target_e),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d),
        .misalign_f  (misalign_f),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a distinct word for every address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    function automatic void model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0000_0013;
        m_pcd   = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_mis   = 1'b0;
        m_count = 32'h0;
    endfunction

    // One clock edge of fetch behaviour, from the stage's rules
    function automatic void model_step(input logic st, input logic fl,
                                       input logic src, input logic [31:0] tgt);
        if (rst) begin
            model_reset();
        end else begin
            if (fl) begin
                m_instr = 32'h0000_0013;
                m_pcd   = 32'h0;
                m_pc4   = 32'h0;
                m_valid = 1'b0;
            end else if (!st) begin
                m_instr = mem_word(m_pc);
                m_pcd   = m_pc;
                m_pc4   = m_pc + 32'd4;
                m_valid = 1'b1;
                m_count = m_count + 32'd1;
            end
            if (src) begin
                m_pc = {tgt[31:1], 1'b0};
                if (tgt[1]) m_mis = 1'b1;
            end else if (!st) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, step the model on the
    // rising edge and return at the next falling edge.
    task automatic applyStimulus(input logic st, input logic fl,
                                 input logic src, input logic [31:0] tgt);
        stall_f     = st;
        flush_d     = fl;
        pc_src_e    = src;
        pc_target_e = tgt;
        @(posedge clk);
        model_step(st, fl, src, tgt);
        @(negedge clk);
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("imem_addr",   imem_addr,          m_pc);
            checkOutput("instr_d",     instr_d,            m_instr);
            checkOutput("pc_d",        pc_d,               m_pcd);
            checkOutput("pc_plus4_d",  pc_plus4_d,         m_pc4);
            checkOutput("valid_d",     {31'b0, valid_d},   {31'b0, m_valid});
            checkOutput("misalign_f",  {31'b0, misalign_f},{31'b0, m_mis});
            checkOutput("fetch_count", fetch_count,        m_count);
        end
    end

    initial begin
        checks      = 0;
        passes      = 0;
        checking    = 1'b0;
        rst         = 1'b1;
        stall_f     = 1'b0;
        flush_d     = 1'b0;
        pc_src_e    = 1'b0;
        pc_target_e = 32'h0;
        model_reset();

        @(negedge clk);
        checking = 1'b1;
        #2 rst = 1'b0;

        // Sequential fetch from reset
        checkOutput("reset_addr", imem_addr, 32'h0);
        checkOutput("reset_valid", {31'b0, valid_d}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("seq_instr0", instr_d, 32'hC0DE_0000);
        checkOutput("seq_addr4", imem_addr, 32'h4);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("seq_instr4", instr_d, 32'hC0DA_0004);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("seq_instr8", instr_d, 32'hC0D6_0008);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("seq_instr12", instr_d, 32'hC0D2_000C);
        checkOutput("seq_addr16", imem_addr, 32'h10);
        checkOutput("seq_count4", fetch_count, 32'd4);

        // Redirect with flush at PC=16
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h30);
        checkOutput("redir_addr", imem_addr, 32'h30);
        checkOutput("redir_bubble", instr_d, 32'h0000_0013);
        checkOutput("redir_valid", {31'b0, valid_d}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("redir_instr", instr_d, 32'hC0EE_0030);
        checkOutput("redir_pcd", pc_d, 32'h30);
        checkOutput("redir_count", fetch_count, 32'd5);

        // Stall for three cycles with PC=8 and mem[4] in IF/ID
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h4);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
            checkOutput("stall_addr", imem_addr, 32'h8);
            checkOutput("stall_instr", instr_d, 32'hC0DA_0004);
            checkOutput("stall_count", fetch_count, 32'd6);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("resume_instr", instr_d, 32'hC0D6_0008);
        checkOutput("resume_addr", imem_addr, 32'hC);

        // Misaligned targets
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h25);
        checkOutput("mis25_addr", imem_addr, 32'h24);
        checkOutput("mis25_flag", {31'b0, misalign_f}, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h26);
        checkOutput("mis26_addr", imem_addr, 32'h26);
        checkOutput("mis26_flag", {31'b0, misalign_f}, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("mis_sticky", {31'b0, misalign_f}, 32'h1);
        checkOutput("mis_count", fetch_count, 32'd8);

        // Redirect, stall and flush together
        saved_count = fetch_count;
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
        checkOutput("all3_addr", imem_addr, 32'h40);
        checkOutput("all3_instr", instr_d, 32'h0000_0013);
        checkOutput("all3_count", fetch_count, 32'd8);

        // PC+4 wraps to zero
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("wrap_addr", imem_addr, 32'h0);
        checkOutput("wrap_pcd", pc_d, 32'hFFFF_FFFC);
        checkOutput("wrap_pc4", pc_plus4_d, 32'h0);

        // Randomized hazards and redirects
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 3) == 0,
                          $urandom_range(0, 4) == 0,
                          $urandom_range(0, 6) == 0,
                          32'($urandom_range(0, 255)));
        end

        // Asynchronous reset mid-cycle at PC=0x1C
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h18);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("prereset_addr", imem_addr, 32'h1C);
        #2 rst = 1'b1;
        model_reset();
        #1;
        checkOutput("arst_addr", imem_addr, 32'h0);
        checkOutput("arst_instr", instr_d, 32'h0000_0013);
        checkOutput("arst_pcd", pc_d, 32'h0);
        checkOutput("arst_pc4", pc_plus4_d, 32'h0);
        checkOutput("arst_valid", {31'b0, valid_d}, 32'h0);
        checkOutput("arst_mis", {31'b0, misalign_f}, 32'h0);
        checkOutput("arst_count", fetch_count, 32'h0);
        @(posedge clk);
        model_step(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("restart_instr", instr_d, 32'hC0DE_0000);
        checkOutput("restart_addr", imem_addr, 32'h4);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        checking = 1'b0;
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage RISC-V pipeline: the initiator side of the instruction memory interface. It owns the program counter, drives the byte address to the combinational instruction memory, and captures the returned word into the IF/ID pipeline register. It handles stalls from the hazard unit, branch and jump redirects from the Execute stage, and Decode flushes.

## Interface
- `ADDR_WIDTH`, 32: PC and memory address width.
- `INST_WIDTH`, 32: instruction width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: reset, asynchronous and active-high.
- `stall_f  in  1`: hold PC and IF/ID contents (load-use hazard).
- `flush_d  in  1`: replace IF/ID contents with a bubble.
- `pc_src_e  in  1`: redirect request from Execute (taken branch, jal, jalr).
- `pc_target_e  in  ADDR_WIDTH`: redirect target.
- `imem_addr  out  ADDR_WIDTH`: byte address to instruction memory. Equal to the current PC.
- `imem_rdata  in  INST_WIDTH`: instruction word, combinational from `imem_addr`.
- `instr_d  out  INST_WIDTH`: IF/ID instruction.
- `pc_d  out  ADDR_WIDTH`: IF/ID PC.
- `pc_plus4_d  out  ADDR_WIDTH`: IF/ID PC+4.
- `valid_d  out  1`: IF/ID holds a real instruction.
- `misalign_f  out  1`: sticky flag, set when a redirect target has bit 1 set.
- `fetch_count  out  32`: number of valid instructions loaded into IF/ID.

## Operation
- The memory is word-per-entry and indexed by byte address. `imem_addr` = PC with no shift, and PC steps by 4.
- PC next-value priority: `rst` > `pc_src_e` > `stall_f` > PC+4.
  - Redirect loads `{pc_target_e[ADDR_WIDTH-1:1], 1'b0}`. Bit 0 is always cleared (jalr rule).
  - If the target's bit 1 = 1, `misalign_f` is set. It stays set until `rst`. The PC still loads the target.
- IF/ID next-value priority: `rst` > `flush_d` > `stall_f` > load.
  - Load: `instr_d`=`imem_rdata`, `pc_d`=PC, `pc_plus4_d`=PC+4, `valid_d`=1.
  - Flush/bubble: `instr_d`=NOP (32'h0000_0013, addi x0,x0,0), `pc_d`=0, `pc_plus4_d`=0, `valid_d`=0.
  - Stall: all IF/ID fields hold.
- Simultaneous events:
  - `pc_src_e` with `stall_f`: the PC redirects, and IF/ID follows the `flush_d`/`stall_f` priority above.
  - `flush_d` with `stall_f`: the flush wins.
- `fetch_count` increments by 1 on every edge where IF/ID performs a load (not stalled, not flushed, not in reset). It wraps from 2^32-1 to 0.
- Arithmetic is modulo 2^ADDR_WIDTH. PC+4 at 32'hFFFF_FFFC wraps to 0 with no flag.

## Timing
- Reset values, applied asynchronously:
  - PC = `RESET_PC`, so `imem_addr` = `RESET_PC` immediately.
  - `instr_d` = NOP, `pc_d` = 0, `pc_plus4_d` = 0.
  - `valid_d` = 0, `misalign_f` = 0, `fetch_count` = 0.
- Fetch latency: the instruction at PC appears on `instr_d` one edge after PC is presented.
- Release of `rst` mid-cycle: the first capture is on the first rising edge with `rst`=0. That edge loads `mem[RESET_PC]` into IF/ID and sets PC=`RESET_PC`+4.
- Redirect: `pc_src_e` sampled high at edge N gives PC=target after N. The target instruction is on `instr_d` after N+1. The hazard unit asserts `flush_d` at N to kill the wrong-path word.
- Stall: while `stall_f`=1, `imem_addr` and every IF/ID output are constant, and `fetch_count` does not increment.
- No outputs depend combinationally on inputs except `imem_addr`, which is the PC register output.

## Structure
- Shared package `riscv_pkg`:
  - `NOP_INSTR` = 32'h0000_0013
  - `INSTR_BYTES` = 4
  - default `RESET_PC`
- Sub-module `pc_reg`: PC register with async reset, enable (~`stall_f` | `pc_src_e`) and next-PC mux.
- The IF/ID register, misalign flag and counter stay in `fetch_stage`.

## Test plan
- Reset then run 5 cycles with the memory preloaded at bytes 0, 4, 8, 12: `imem_addr` goes 0, 4, 8, 12, 16; `instr_d` shows `mem[0]`…`mem[12]` one cycle late; `valid_d`=1; `fetch_count`=4 after 4 loads.
- `stall_f` high for 3 cycles at PC=8: `imem_addr` stays 8 and `instr_d` stays `mem[4]` for 3 cycles; `fetch_count` is unchanged; fetch resumes at 8 on release.
- `pc_src_e`=1, `pc_target_e`=32'h30, `flush_d`=1 at PC=16: next PC=0x30; next `instr_d`=0x00000013 with `valid_d`=0; the following `instr_d`=`mem[0x30]` with `pc_d`=0x30.
- Redirect to 32'h25, then separately to 32'h26: first gives PC=0x24 and `misalign_f`=0; second gives PC=0x26 and `misalign_f`=1, which holds until `rst`.
- `pc_src_e`, `stall_f` and `flush_d` all high together: PC takes the target, IF/ID becomes a bubble, `fetch_count` is unchanged.
- Assert `rst` asynchronously mid-run at PC=0x1C: all outputs return to reset values before the next edge; after release, fetch restarts at `RESET_PC`.
